// File: rtl/mac_vector_sequencer.sv
// rtl/mac_vector_sequencer.sv - dot-product sequencer driving a shared memory port and the ALU
module mac_vector_sequencer #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [LEN_W-1:0]  vec_len,
   input  logic [ADDR_W-1:0] base_a,
   input  logic [ADDR_W-1:0] base_b,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic              relu_en,
   output logic              busy,
   output logic              done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_gnt,
   input  logic [31:0]       mem_rdata,
   output logic [3:0]        alu_op,
   output logic [5:0]        alu_funct,
   output logic [31:0]       alu_in1,
   output logic [31:0]       alu_in2,
   input  logic [31:0]       alu_result
);

   localparam logic [3:0] OP_RTYPE   = 4'b0010;
   localparam logic [5:0] FUNCT_MAC  = 6'b101101;
   localparam logic [5:0] FUNCT_RELU = 6'b101110;

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, MAC, RELU, WR, DONE} state_t;

   state_t            state;
   state_t            state_nx;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  idx;
   logic [LEN_W-1:0]  idx_inc;
   logic [ADDR_W-1:0] base_a_q;
   logic [ADDR_W-1:0] base_b_q;
   logic [ADDR_W-1:0] dst_q;
   logic [ADDR_W-1:0] elem_off;
   logic              relu_q;
   logic [31:0]       acc;
   logic [31:0]       res;
   logic [15:0]       a_reg;
   logic              rdb_first;
   logic              unused_bits;

   assign idx_inc     = idx + LEN_W'(1);
   assign elem_off    = ADDR_W'(idx) << 2;
   assign unused_bits = ^mem_rdata[31:16];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = (vec_len != '0) ? RD_A : RELU;
         RD_A:    if (mem_gnt) state_nx = RD_B;
         RD_B:    if (mem_gnt) state_nx = MAC;
         MAC:     state_nx = (idx_inc == len_q) ? RELU : RD_A;
         RELU:    state_nx = WR;
         WR:      if (mem_gnt) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      done      = (state == DONE);
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      alu_op    = 4'b0000;
      alu_funct = 6'b000000;
      alu_in1   = '0;
      alu_in2   = '0;
      unique case (state)
         RD_A: begin
            mem_req  = 1'b1;
            mem_addr = base_a_q + elem_off;
         end
         RD_B: begin
            mem_req  = 1'b1;
            mem_addr = base_b_q + elem_off;
         end
         MAC: begin
            alu_op    = OP_RTYPE;
            alu_funct = FUNCT_MAC;
            alu_in1   = acc;
            alu_in2   = {a_reg, mem_rdata[15:0]};
         end
         RELU: begin
            if (relu_q) begin
               alu_op    = OP_RTYPE;
               alu_funct = FUNCT_RELU;
               alu_in1   = acc;
            end
         end
         WR: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = dst_q;
            mem_wdata = res;
         end
         default: ;
      endcase
   end

   // a_reg is taken only in the first RD_B cycle: rdata is valid just once after the A grant
   always_ff @(posedge clk) begin
      if (reset) begin
         len_q     <= '0;
         idx       <= '0;
         base_a_q  <= '0;
         base_b_q  <= '0;
         dst_q     <= '0;
         relu_q    <= 1'b0;
         acc       <= '0;
         res       <= '0;
         a_reg     <= '0;
         rdb_first <= 1'b0;
      end else begin
         rdb_first <= (state == RD_A) && mem_gnt;
         unique case (state)
            IDLE: begin
               if (start) begin
                  len_q    <= vec_len;
                  base_a_q <= base_a;
                  base_b_q <= base_b;
                  dst_q    <= dst_addr;
                  relu_q   <= relu_en;
                  acc      <= '0;
                  idx      <= '0;
               end
            end
            RD_B: if (rdb_first) a_reg <= mem_rdata[15:0];
            MAC: begin
               acc <= alu_result;
               idx <= idx_inc;
            end
            RELU: res <= relu_q ? alu_result : acc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_vector_sequencer.sv
// tb/tb_mac_vector_sequencer.sv - self-checking bench with memory, ALU and dot-product reference model
module tb_mac_vector_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  vec_len;
   logic [31:0] base_a;
   logic [31:0] base_b;
   logic [31:0] dst_addr;
   logic        relu_en;
   logic        busy;
   logic        done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt = 1'b1;
   logic [31:0] mem_rdata = 32'd0;
   logic [3:0]  alu_op;
   logic [5:0]  alu_funct;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [31:0] alu_result;

   logic [31:0] mem [0:1023];
   int n_checks = 0;
   int n_fail   = 0;
   int gnt_mode = 0;
   int stall_arm = 0;
   int stall_seen = 0;
   int stall_left = 0;
   logic [31:0] stall_addr = 32'd0;

   logic signed [15:0] alu_h1;
   logic signed [15:0] alu_h2;

   mac_vector_sequencer #(.ADDR_W(32), .LEN_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .vec_len(vec_len),
      .base_a(base_a), .base_b(base_b), .dst_addr(dst_addr), .relu_en(relu_en),
      .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
      .alu_op(alu_op), .alu_funct(alu_funct), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_result(alu_result)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_h1 = alu_in2[31:16];
      alu_h2 = alu_in2[15:0];
      alu_result = 32'd0;
      if (alu_op == 4'b0010 && alu_funct == 6'b101101)
         alu_result = alu_in1 + 32'(int'(alu_h1) * int'(alu_h2));
      else if (alu_op == 4'b0010 && alu_funct == 6'b101110)
         alu_result = alu_in1[31] ? 32'd0 : alu_in1;
   end

   // read data valid only the cycle after a granted read; garbage otherwise
   always @(posedge clk) begin
      if (mem_req && mem_gnt && !mem_we) mem_rdata <= mem[mem_addr[11:2]];
      else                               mem_rdata <= $urandom;
   end

   always @(posedge clk) begin
      #1;
      if (stall_arm != stall_seen) begin
         stall_seen = stall_arm;
         stall_left = 3;
      end
      if (gnt_mode == 2 && stall_left > 0 && mem_req && !mem_we && mem_addr == stall_addr) begin
         mem_gnt = 1'b0;
         stall_left--;
      end else if (gnt_mode == 1) mem_gnt = 1'($urandom_range(0, 1));
      else mem_gnt = 1'b1;
   end

   function automatic logic [31:0] model(input logic [7:0] len, input logic [31:0] ba,
                                         input logic [31:0] bb, input logic relu);
      int s;
      logic [31:0] aa, ab;
      logic signed [15:0] ha, hb;
      s = 0;
      for (int i = 0; i < int'(len); i++) begin
         aa = ba + 32'(i) * 32'd4;
         ab = bb + 32'(i) * 32'd4;
         ha = mem[aa[11:2]][15:0];
         hb = mem[ab[11:2]][15:0];
         s += int'(ha) * int'(hb);
      end
      if (relu && s < 0) s = 0;
      return 32'(s);
   endfunction

   task automatic run_op(input logic [7:0] len, input logic [31:0] ba, input logic [31:0] bb,
                         input logic [31:0] dst, input logic relu, input bit noise,
                         output int cyc, output int nwr, output int nrd,
                         output logic [31:0] waddr, output logic [31:0] wdata,
                         output int holds, output int busy_bad);
      bit pst;
      logic [31:0] pa;
      logic pw;
      pst = 0; pa = 0; pw = 0;
      cyc = -1; nwr = 0; nrd = 0; waddr = 0; wdata = 0; holds = 0; busy_bad = 0;
      @(negedge clk);
      vec_len = len; base_a = ba; base_b = bb; dst_addr = dst; relu_en = relu; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c < 3000; c++) begin
         if (pst && (mem_req !== 1'b1 || mem_addr !== pa || mem_we !== pw)) holds++;
         pst = mem_req && !mem_gnt; pa = mem_addr; pw = mem_we;
         if (busy !== 1'b1) busy_bad++;
         if (mem_req && mem_gnt) begin
            if (mem_we) begin nwr++; waddr = mem_addr; wdata = mem_wdata; end
            else nrd++;
         end
         if (done === 1'b1) begin cyc = c; break; end
         if (noise) begin
            start = 1'($urandom_range(0, 1)); vec_len = 8'($urandom); base_a = $urandom;
            base_b = $urandom; dst_addr = $urandom; relu_en = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; vec_len = 0; base_a = 0; base_b = 0; dst_addr = 0; relu_en = 0;
      repeat (3) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_checks++; if ({mem_req, mem_we} !== 2'b00) begin n_fail++; $display("FAIL reset_req_we got %b want 00", {mem_req, mem_we}); end
      n_checks++; if ({mem_addr, mem_wdata} !== 64'd0) begin n_fail++; $display("FAIL reset_addr_wdata got %h want 0", {mem_addr, mem_wdata}); end
      n_checks++; if ({alu_op, alu_funct, alu_in1, alu_in2} !== 74'd0) begin n_fail++; $display("FAIL reset_alu got %h want 0", {alu_op, alu_funct, alu_in1, alu_in2}); end
      reset = 1'b0;
   endtask

   task automatic test_directed;
      int cyc, nwr, nrd, holds, bb;
      logic [31:0] wa, wd;
      mem[64] = 32'd3; mem[65] = 32'hFFFF_FFFE; mem[128] = 32'd4; mem[129] = 32'd5;
      run_op(8'd2, 32'h100, 32'h200, 32'h300, 1'b1, 0, cyc, nwr, nrd, wa, wd, holds, bb);
      n_checks++; if (wd !== 32'd2) begin n_fail++; $display("FAIL len2_result got %h want 2", wd); end
      n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL len2_latency got %0d want 9", cyc); end
      n_checks++; if (wa !== 32'h300 || nwr !== 1) begin n_fail++; $display("FAIL len2_write got addr %h n %0d want 300 n 1", wa, nwr); end
      n_checks++; if (nrd !== 4 || bb !== 0) begin n_fail++; $display("FAIL len2_reads_busy got %0d/%0d want 4/0", nrd, bb); end
      mem[64] = 32'd1; mem[128] = 32'hFFFF_FFF9;
      run_op(8'd1, 32'h100, 32'h200, 32'h304, 1'b1, 0, cyc, nwr, nrd, wa, wd, holds, bb);
      n_checks++; if (wd !== 32'd0 || cyc !== 6) begin n_fail++; $display("FAIL len1_relu got %h cyc %0d want 0 cyc 6", wd, cyc); end
      run_op(8'd1, 32'h100, 32'h200, 32'h304, 1'b0, 0, cyc, nwr, nrd, wa, wd, holds, bb);
      n_checks++; if (wd !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL len1_norelu got %h want fffffff9", wd); end
      run_op(8'd0, 32'h100, 32'h200, 32'h308, 1'b0, 0, cyc, nwr, nrd, wa, wd, holds, bb);
      n_checks++; if (wd !== 32'd0 || wa !== 32'h308 || nwr !== 1) begin n_fail++; $display("FAIL len0_write got %h@%h n %0d want 0@308 n 1", wd, wa, nwr); end
      n_checks++; if (nrd !== 0 || cyc !== 3) begin n_fail++; $display("FAIL len0_timing got reads %0d cyc %0d want 0 3", nrd, cyc); end
   endtask

   task automatic test_stall;
      int cyc, nwr, nrd, holds, bb;
      logic [31:0] wa, wd;
      mem[64] = 32'd3; mem[65] = 32'hFFFF_FFFE; mem[128] = 32'd4; mem[129] = 32'd5;
      stall_addr = 32'h200; gnt_mode = 2; stall_arm++;
      run_op(8'd2, 32'h100, 32'h200, 32'h300, 1'b1, 0, cyc, nwr, nrd, wa, wd, holds, bb);
      gnt_mode = 0;
      n_checks++; if (wd !== 32'd2) begin n_fail++; $display("FAIL stall_result got %h want 2", wd); end
      n_checks++; if (cyc !== 12) begin n_fail++; $display("FAIL stall_latency got %0d want 12", cyc); end
      n_checks++; if (holds !== 0) begin n_fail++; $display("FAIL stall_hold got %0d unstable cycles want 0", holds); end
   endtask

   task automatic test_ignore_start;
      int cyc, nwr, nrd, holds, bb;
      logic [31:0] wa, wd, exp;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      exp = model(8'd3, 32'h400, 32'h800, 1'b0);
      run_op(8'd3, 32'h400, 32'h800, 32'hC00, 1'b0, 1, cyc, nwr, nrd, wa, wd, holds, bb);
      n_checks++; if (wd !== exp || wa !== 32'hC00) begin n_fail++; $display("FAIL ignore_start got %h@%h want %h@c00", wd, wa, exp); end
      n_checks++; if (cyc !== 12 || nwr !== 1) begin n_fail++; $display("FAIL ignore_start_timing got cyc %0d n %0d want 12 1", cyc, nwr); end
   endtask

   task automatic test_back_to_back;
      int cyc, nwr, nrd, holds, bb;
      logic [31:0] wa, wd, exp;
      for (int k = 0; k < 2; k++) begin
         exp = model(8'(k + 4), 32'hFFFF_FFF8, 32'h804, 1'(k));
         run_op(8'(k + 4), 32'hFFFF_FFF8, 32'h804, 32'h10, 1'(k), 0, cyc, nwr, nrd, wa, wd, holds, bb);
         n_checks++; if (wd !== exp || cyc !== 3 * (k + 4) + 3) begin n_fail++; $display("FAIL b2b_wrap_%0d got %h cyc %0d want %h cyc %0d", k, wd, cyc, exp, 3 * (k + 4) + 3); end
      end
      @(negedge clk);
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_after_done got busy %b done %b want 0 0", busy, done); end
   endtask

   task automatic test_random;
      int cyc, nwr, nrd, holds, bb, len;
      logic [31:0] wa, wd, exp, ba, bv, dst;
      logic rl;
      gnt_mode = 1;
      for (int it = 0; it < 16; it++) begin
         for (int i = 0; i < 1024; i++) mem[i] = $urandom;
         len = (it == 15) ? 255 : $urandom_range(0, 12);
         if (it == 15) gnt_mode = 0;
         ba = $urandom & 32'hFFFF_FFFC; bv = $urandom & 32'hFFFF_FFFC; dst = $urandom & 32'hFFFF_FFFC;
         rl = 1'($urandom_range(0, 1));
         exp = model(8'(len), ba, bv, rl);
         run_op(8'(len), ba, bv, dst, rl, 0, cyc, nwr, nrd, wa, wd, holds, bb);
         n_checks++;
         if (wd !== exp || wa !== dst || nwr !== 1 || nrd !== 2 * len || holds !== 0 || bb !== 0 || cyc < 0)
            begin n_fail++; $display("FAIL random_%0d len %0d got %h@%h w%0d r%0d h%0d b%0d c%0d want %h@%h w1 r%0d", it, len, wd, wa, nwr, nrd, holds, bb, cyc, exp, dst, 2 * len); end
      end
      n_checks++; if (cyc !== 768) begin n_fail++; $display("FAIL len255_latency got %0d want 768", cyc); end
      gnt_mode = 0;
   endtask

   task automatic test_reset_mid;
      int macs, bad;
      bit hit;
      macs = 0; bad = 0; hit = 0;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      @(negedge clk);
      vec_len = 8'd4; base_a = 32'h100; base_b = 32'h200; dst_addr = 32'h300; relu_en = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (alu_funct == 6'b101101) macs++;
         if (macs == 2) begin hit = 1; break; end
         @(negedge clk);
      end
      n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL reset_mid_reach_mac got %0d macs want 2", macs); end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++; if ({busy, mem_req, done} !== 3'b000 || alu_funct !== 6'd0) begin n_fail++; $display("FAIL reset_mid_idle got busy/req/done %b funct %b want 000 0", {busy, mem_req, done}, alu_funct); end
      for (int c = 0; c < 20; c++) begin
         if ((mem_req && mem_we) || done || busy) bad++;
         @(negedge clk);
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL reset_mid_quiet got %0d active cycles want 0", bad); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
      test_reset();
      test_directed();
      test_stall();
      test_ignore_start();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
